// File: rtl/icache_if.sv
// ============================================================================
// icache_if : datapath-fetch and memory-refill signals of the icache.
// Rev 1.0
// ============================================================================
`default_nettype none

interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// icache : direct-mapped one-word-per-frame instruction cache, zero-latency hit.
// Rev 1.0
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS = 16
) (
  input  logic      CLK,
  input  logic      nRST,
  icache_if.slave   bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } state_t;

  state_t            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_fetch;
  logic              w_unused_ofs;

  assign w_idx        = bus.imemaddr[IDX_W+1:2];
  assign w_tag        = bus.imemaddr[31:IDX_W+2];
  assign w_unused_ofs = ^bus.imemaddr[1:0];
  assign w_fetch      = (state_q == FETCH);

  assign w_hit = (state_q == COMPARE) && bus.imemREN && valid_q[w_idx] &&
                 (tag_q[w_idx] == w_tag);

  assign bus.ihit     = w_hit;
  assign bus.imemload = w_hit ? data_q[w_idx] : 32'h0;
  assign bus.iREN     = w_fetch;
  // iaddr tracks the live PC so a redirect mid-refill fetches the new target.
  assign bus.iaddr    = w_fetch ? {bus.imemaddr[31:2], 2'b00} : 32'h0;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= COMPARE;
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else if (state_q == COMPARE) begin
      if (bus.imemREN && !w_hit) begin
        state_q <= FETCH;
      end
    end else begin
      // A dropped request abandons the refill even if memory answers now.
      if (!bus.imemREN) begin
        state_q <= COMPARE;
      end else if (!bus.iwait) begin
        valid_q[w_idx] <= 1'b1;
        tag_q[w_idx]   <= w_tag;
        data_q[w_idx]  <= bus.iload;
        state_q        <= COMPARE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// tb_icache : directed self-checking bench for icache (SETS = 16).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  icache_if bus ();

  icache #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issue a request that should miss, then complete the refill after `waits`
  // busy cycles. Returns at posedge+1 with the FSM back in COMPARE.
  task automatic refill(input logic [31:0] addr, input logic [31:0] data,
                        input int waits, output logic was_miss,
                        output logic fetch_ok);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    #4;
    was_miss = !bus.ihit && (bus.imemload == 32'h0);
    @(posedge CLK); #1;
    fetch_ok = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      bus.iwait = (i < waits);
      bus.iload = data;
      #4;
      if (bus.iREN !== 1'b1 || bus.iaddr !== {addr[31:2], 2'b00} || bus.ihit !== 1'b0)
        fetch_ok = 1'b0;
      @(posedge CLK); #1;
    end
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
  endtask

  task automatic test_reset();
    nRST         = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0 || bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ihit=%b imemload=%h iREN=%b iaddr=%h, required 0/0/0/0",
               bus.ihit, bus.imemload, bus.iREN, bus.iaddr);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic m, f;
    refill(32'h0000_0000, 32'h2001_0005, 3, m, f);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL cold_first_request: miss=%b, required 1", m);
    end
    checks++;
    if (f !== 1'b1) begin
      errors++;
      $display("FAIL cold_fetch_window: iREN/iaddr ok=%b over 4 cycles, required 1", f);
    end
    #1;
    checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2001_0005 || bus.iREN !== 1'b0) begin
      errors++;
      $display("FAIL cold_hit_after_fill: ihit=%b imemload=%h iREN=%b, required 1/20010005/0",
               bus.ihit, bus.imemload, bus.iREN);
    end
  endtask

  task automatic test_repeat_hit();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #4;
      checks++;
      if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2001_0005 || bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
        errors++;
        $display("FAIL repeat_hit[%0d]: ihit=%b imemload=%h iREN=%b iaddr=%h, required 1/20010005/0/0",
                 i, bus.ihit, bus.imemload, bus.iREN, bus.iaddr);
      end
    end
    bus.imemaddr = 32'h0000_0002;
    #1;
    checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2001_0005) begin
      errors++;
      $display("FAIL offset_ignored: ihit=%b imemload=%h, required 1/20010005", bus.ihit, bus.imemload);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #4;
    checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0 || bus.iREN !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_request: ihit=%b imemload=%h iREN=%b, required 0/0/0",
               bus.ihit, bus.imemload, bus.iREN);
    end
    @(posedge CLK); #4;
    checks++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      errors++;
      $display("FAIL idle_stays_compare: iREN=%b iaddr=%h, required 0/0", bus.iREN, bus.iaddr);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_conflict();
    logic m, f;
    refill(32'h0000_0004, 32'hAAAA_0001, 0, m, f);
    #1;
    checks++;
    if (m !== 1'b1 || f !== 1'b1 || bus.ihit !== 1'b1 || bus.imemload !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL conflict_fill_A: miss=%b fetch=%b ihit=%b imemload=%h, required 1/1/1/aaaa0001",
               m, f, bus.ihit, bus.imemload);
    end
    refill(32'h0000_0044, 32'hBBBB_0002, 1, m, f);
    #1;
    checks++;
    if (m !== 1'b1 || f !== 1'b1 || bus.ihit !== 1'b1 || bus.imemload !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL conflict_fill_B: miss=%b fetch=%b ihit=%b imemload=%h, required 1/1/1/bbbb0002",
               m, f, bus.ihit, bus.imemload);
    end
    refill(32'h0000_0004, 32'hAAAA_0001, 0, m, f);
    #1;
    checks++;
    if (m !== 1'b1 || f !== 1'b1 || bus.ihit !== 1'b1 || bus.imemload !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL conflict_refetch_A: miss=%b fetch=%b ihit=%b imemload=%h, required 1/1/1/aaaa0001",
               m, f, bus.ihit, bus.imemload);
    end
    bus.imemaddr = 32'h0000_0044;
    #1;
    checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      errors++;
      $display("FAIL conflict_B_evicted: ihit=%b imemload=%h, required 0/0", bus.ihit, bus.imemload);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_abort();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0010;
    bus.iwait    = 1'b1;
    @(posedge CLK); #4;
    checks++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h0000_0010) begin
      errors++;
      $display("FAIL abort_in_fetch: iREN=%b iaddr=%h, required 1/00000010", bus.iREN, bus.iaddr);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #4;
    checks++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      errors++;
      $display("FAIL abort_back_to_compare: iREN=%b iaddr=%h, required 0/0", bus.iREN, bus.iaddr);
    end
    bus.imemREN = 1'b1;
    #1;
    checks++;
    if (bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL abort_frame_invalid: ihit=%b, required 0", bus.ihit);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_fill();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0020;
    bus.iwait    = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
    checks++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_aborts_fetch: iREN=%b iaddr=%h, required 0/0", bus.iREN, bus.iaddr);
    end
    bus.iwait = 1'b0;
    bus.iload = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    nRST      = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    #1;
    checks++;
    if (bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL reset_rerequest_misses: ihit=%b, required 0", bus.ihit);
    end
    bus.imemaddr = 32'h0000_0004;
    #1;
    checks++;
    if (bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_old_frame: ihit=%b, required 0", bus.ihit);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_redirect();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0008;
    bus.iwait    = 1'b1;
    @(posedge CLK); #4;
    checks++;
    if (bus.iaddr !== 32'h0000_0008) begin
      errors++;
      $display("FAIL redirect_initial_iaddr: iaddr=%h, required 00000008", bus.iaddr);
    end
    @(posedge CLK); #1;
    bus.imemaddr = 32'h0000_0100;
    #1;
    checks++;
    if (bus.iaddr !== 32'h0000_0100 || bus.iREN !== 1'b1) begin
      errors++;
      $display("FAIL redirect_iaddr_follows: iaddr=%h iREN=%b, required 00000100/1", bus.iaddr, bus.iREN);
    end
    bus.iwait = 1'b0;
    bus.iload = 32'h1234_5678;
    @(posedge CLK); #1;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    #1;
    checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1234_5678) begin
      errors++;
      $display("FAIL redirect_fill_new_addr: ihit=%b imemload=%h, required 1/12345678", bus.ihit, bus.imemload);
    end
    bus.imemaddr = 32'h0000_0008;
    #1;
    checks++;
    if (bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL redirect_old_not_filled: ihit=%b, required 0", bus.ihit);
    end
    bus.imemaddr = 32'h0000_0000;
    #1;
    checks++;
    if (bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL redirect_frame0_tag: ihit=%b, required 0", bus.ihit);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_conflict();
    test_abort();
    test_reset_mid_fill();
    test_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter SETS, default 16, meaning number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have port nRST  input  1  reset, asynchronous and active-high (asserted when 1).
REQ-004 The block SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 The block SHALL have port imemaddr  input  32  datapath fetch byte address, i.e. the PC.
REQ-006 The block SHALL have port ihit  output  1  requested word valid this cycle; the datapath uses it as the PC write enable and pipeline-latch advance.
REQ-007 The block SHALL have port imemload  output  32  instruction word for imemaddr.
REQ-008 The block SHALL have port iREN  output  1  memory-side read request.
REQ-009 The block SHALL have port iaddr  output  32  memory-side word address.
REQ-010 The block SHALL have port iwait  input  1  memory busy; 0 means iload is valid this cycle.
REQ-011 The block SHALL have port iload  input  32  memory read data.

Function
REQ-012 Address split SHALL be: byte offset [1:0] (ignored), index [log2(SETS)+1:2], tag = remaining upper bits [31:log2(SETS)+2].
REQ-013 Each frame SHALL hold valid (1 bit), tag, and data (32 bits), all in flops.
REQ-014 The FSM SHALL have two states, COMPARE and FETCH, with reset state COMPARE.
REQ-015 In COMPARE, a hit SHALL be imemREN=1 AND frame valid AND stored tag equals the address tag.
REQ-016 On a hit, ihit SHALL be 1 and imemload SHALL be the frame data in the same cycle (zero-latency, combinational), and the state SHALL not change.
REQ-017 In COMPARE on a miss with imemREN=1, ihit SHALL be 0 and the FSM SHALL go to FETCH on the next edge.
REQ-018 In COMPARE with imemREN=0, ihit SHALL be 0, iREN SHALL be 0, and the state SHALL stay COMPARE.
REQ-019 In FETCH, iREN SHALL be 1, iaddr SHALL be {imemaddr[31:2],2'b00}, and ihit SHALL be 0.
REQ-020 In FETCH with iwait=1, the FSM SHALL hold in FETCH and no frame SHALL change.
REQ-021 In FETCH with iwait=0, the indexed frame SHALL load data=iload, tag=address tag, valid=1, and the FSM SHALL return to COMPARE on that edge.
REQ-022 The refill word SHALL NOT be forwarded as a hit in the FETCH cycle; the hit occurs in the following COMPARE cycle, for a minimum miss penalty of 2 cycles.
REQ-023 In FETCH with imemREN dropped to 0, the FSM SHALL return to COMPARE with no frame update, regardless of iwait.
REQ-024 If imemaddr changes during FETCH (pipeline redirect/flush), iaddr SHALL follow the new address; the completed refill SHALL write the frame selected by the current address.
REQ-025 A refill SHALL replace the valid frame at that index unconditionally (direct-mapped, no write-back, no dirty state).
REQ-026 Outside FETCH, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-027 When ihit=0, imemload SHALL be 0.

Reset
REQ-028 While nRST=1, the state SHALL be COMPARE, every valid bit SHALL be 0, tags and data SHALL be 0, and the outputs SHALL be ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-029 Asserting nRST mid-FETCH SHALL abort the refill immediately with no frame written.
REQ-030 After nRST deassertion, the first request SHALL be treated as a miss.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x00000000, iwait=1 for 3 cycles then 0 with iload=0x20010005 -> iREN=1 and iaddr=0 for 4 cycles; ihit=1 with imemload=0x20010005 in the next cycle.
REQ-032 Repeat hit: after the fill of REQ-031, hold imemaddr=0x00000000 -> ihit=1 every cycle with iREN=0; changing imemaddr to 0x00000002 still hits (offset ignored).
REQ-033 Conflict eviction (SETS=16): fill 0x00000004 (data A), then 0x00000044 (data B), then request 0x00000004 again -> third request misses and refetches A; 0x00000044 then misses.
REQ-034 Abort: miss on 0x00000010, drop imemREN while iwait=1 -> FSM returns to COMPARE next edge, iREN=0, and frame 4 stays invalid.
REQ-035 Reset mid-fill: assert nRST during FETCH, then iwait=0 -> no frame valid; re-request misses.
REQ-036 Redirect: miss on 0x00000008, change imemaddr to 0x00000100 before iwait=0 -> iaddr=0x00000100, and frame 0 is filled with tag for 0x100.
